// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out converter.
//
// Captures a SIZE_DATA_IN-bit word on a start request and emits it as
// SIZE_DATA_IN/SIZE_DATA_OUT chunks of SIZE_DATA_OUT bits, one per clock.
// A valid strobe accompanies every chunk, and a done pulse marks the last one.
// Holding i_start high during the done cycle recaptures i_data, so the next
// word follows without a bubble.
//
// Configuration macro:
//   PISO_LSB_FIRST_EN  defined   -> least-significant chunk is emitted first
//                      undefined -> most-significant chunk is emitted first (default)
//
// Ports:
//   i_clk    in   1              clock, rising edge
//   i_rst    in   1              asynchronous active-high reset
//   i_start  in   1              capture i_data and begin serialising
//   i_data   in   SIZE_DATA_IN   parallel word, sampled only on capture
//   o_data   out  SIZE_DATA_OUT  current serial chunk (registered)
//   o_valid  out  1              o_data holds a valid chunk
//   o_done   out  1              high together with the last chunk of a word

module piso_serializer #(
    parameter int unsigned SIZE_DATA_IN  = 16,
    parameter int unsigned SIZE_DATA_OUT = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [SIZE_DATA_IN-1:0]  i_data,
    output logic [SIZE_DATA_OUT-1:0] o_data,
    output logic                     o_valid,
    output logic                     o_done
);

    localparam int unsigned N     = SIZE_DATA_IN / SIZE_DATA_OUT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if ((SIZE_DATA_IN % SIZE_DATA_OUT) != 0 || SIZE_DATA_IN < SIZE_DATA_OUT) begin : g_bad_cfg
        $error("piso_serializer: SIZE_DATA_IN must be a positive multiple of SIZE_DATA_OUT");
    end

    typedef enum logic {
        StIdle,
        StShift
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [SIZE_DATA_IN-1:0] shreg;

    // Chunk presented next from a word, according to the configured order.
    function automatic logic [SIZE_DATA_OUT-1:0] head(input logic [SIZE_DATA_IN-1:0] w);
`ifdef PISO_LSB_FIRST_EN
        return w[SIZE_DATA_OUT-1:0];
`else
        return w[SIZE_DATA_IN-1 -: SIZE_DATA_OUT];
`endif
    endfunction

    // Word with its presented chunk removed.
    function automatic logic [SIZE_DATA_IN-1:0] advance(input logic [SIZE_DATA_IN-1:0] w);
`ifdef PISO_LSB_FIRST_EN
        return w >> SIZE_DATA_OUT;
`else
        return w << SIZE_DATA_OUT;
`endif
    endfunction

    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] idx);
        return (idx == LAST) ? '0 : idx + CNT_W'(1);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= StIdle;
            cnt     <= '0;
            shreg   <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    o_data  <= '0;
                    o_valid <= 1'b0;
                    o_done  <= 1'b0;
                    if (i_start) begin
                        shreg <= i_data;
                        cnt   <= '0;
                        state <= StShift;
                    end
                end

                StShift: begin
                    if (!o_done) begin
                        // Mid-frame: present the chunk at index cnt.
                        o_data  <= head(shreg);
                        shreg   <= advance(shreg);
                        o_valid <= 1'b1;
                        o_done  <= (cnt == LAST);
                        cnt     <= next_cnt(cnt);
                    end else if (i_start) begin
                        // Last chunk is on the output: reload and present chunk 0
                        // straight from i_data so there is no gap.
                        o_data  <= head(i_data);
                        shreg   <= advance(i_data);
                        o_valid <= 1'b1;
                        o_done  <= (LAST == '0);
                        cnt     <= next_cnt('0);
                    end else begin
                        o_data  <= '0;
                        o_valid <= 1'b0;
                        o_done  <= 1'b0;
                        shreg   <= '0;
                        cnt     <= '0;
                        state   <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [15:0] i_data;
    logic [1:0] o_data;
    logic       o_valid;
    logic       o_done;

    int total = 0;
    int bad   = 0;

    // Expected chunk sequences, first chunk in the top two bits.
`ifdef PISO_LSB_FIRST_EN
    localparam logic [15:0] SEQ_1234 = 16'h1C84;  // 00,01,11,00,10,00,01,00
    localparam logic [15:0] SEQ_5678 = 16'h2D95;  // 00,10,11,01,10,01,01,01
`else
    localparam logic [15:0] SEQ_1234 = 16'h1234;  // 00,01,00,10,00,11,01,00
    localparam logic [15:0] SEQ_5678 = 16'h5678;  // 01,01,01,10,01,11,10,00
`endif

    piso_serializer #(
        .SIZE_DATA_IN (16),
        .SIZE_DATA_OUT(2)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_data (i_data),
        .o_data (o_data),
        .o_valid(o_valid),
        .o_done (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] d, input logic v,
                                 input logic dn);
        check({tag, ".data"}, {14'd0, o_data}, {14'd0, d});
        check({tag, ".valid"}, {15'd0, o_valid}, {15'd0, v});
        check({tag, ".done"}, {15'd0, o_done}, {15'd0, dn});
    endtask

    task automatic expect_idle(input string tag);
        @(negedge i_clk);
        check_outputs(tag, 2'b00, 1'b0, 1'b0);
    endtask

    // Waits one cycle and checks chunk j of a packed expected sequence.
    task automatic expect_chunk(input string tag, input logic [15:0] seq, input int j);
        logic [1:0] c;
        c = seq[15 - 2 * j -: 2];
        @(negedge i_clk);
        check_outputs($sformatf("%s.c%0d", tag, j), c, 1'b1, (j == 7));
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b1;
        i_data  = 16'h1234;

        // 1: outputs stay at reset values while reset is held, even with i_start high.
        for (int i = 0; i < 3; i++) expect_idle("rst_hold");

        // 2: no start request -> nothing emitted.
        i_rst   = 1'b0;
        i_start = 1'b0;
        for (int i = 0; i < 10; i++) expect_idle("no_start");

        // 3: single-cycle start; first chunk one cycle after capture.
        i_start = 1'b1;
        i_data  = 16'h1234;
        expect_idle("t3.lat");
        i_start = 1'b0;
        for (int j = 0; j < 8; j++) expect_chunk("t3", SEQ_1234, j);
        expect_idle("t3.post0");
        expect_idle("t3.post1");

        // 4: i_data changes mid-frame are ignored.
        i_start = 1'b1;
        i_data  = 16'h1234;
        expect_idle("t4.lat");
        i_start = 1'b0;
        expect_chunk("t4", SEQ_1234, 0);
        expect_chunk("t4", SEQ_1234, 1);
        i_data = 16'h5678;
        for (int j = 2; j < 8; j++) expect_chunk("t4", SEQ_1234, j);
        expect_idle("t4.post");

        // 5: start held high -> back-to-back frames; dropping start mid-frame
        // still lets that frame complete.
        i_start = 1'b1;
        i_data  = 16'h5678;
        expect_idle("t5.lat");
        for (int j = 0; j < 8; j++) expect_chunk("t5a", SEQ_5678, j);
        expect_chunk("t5b", SEQ_5678, 0);
        expect_chunk("t5b", SEQ_5678, 1);
        i_start = 1'b0;
        for (int j = 2; j < 8; j++) expect_chunk("t5b", SEQ_5678, j);
        expect_idle("t5.post0");
        expect_idle("t5.post1");

        // 6: reset during chunk 4 clears outputs asynchronously; no done follows.
        i_start = 1'b1;
        i_data  = 16'h1234;
        expect_idle("t6.lat");
        i_start = 1'b0;
        for (int j = 0; j < 5; j++) expect_chunk("t6", SEQ_1234, j);
        i_rst = 1'b1;
        #1;
        check_outputs("t6.async", 2'b00, 1'b0, 1'b0);
        expect_idle("t6.rst0");
        expect_idle("t6.rst1");
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) expect_idle("t6.after");

        // Restart after the aborted frame gives a full frame.
        i_start = 1'b1;
        i_data  = 16'h1234;
        expect_idle("t6r.lat");
        i_start = 1'b0;
        for (int j = 0; j < 8; j++) expect_chunk("t6r", SEQ_1234, j);
        expect_idle("t6r.post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
